// File: rtl/yuv2rgb_if.sv
// yuv2rgb_if: pixel bus into and out of the YUV->RGB converter.
// slave = converter side, master = pixel source/sink side.
`ifndef DTYPE_WIDTH
`define DTYPE_WIDTH 4
`endif

interface yuv2rgb_if #(
  parameter int unsigned PIXEL_WIDTH = 8
);
  localparam int unsigned DW = `DTYPE_WIDTH;
  localparam int unsigned MW = 16;

  logic                   dvi;
  logic [DW-1:0]          dtypei;
  logic [PIXEL_WIDTH-1:0] y;
  logic [PIXEL_WIDTH-1:0] u;
  logic [PIXEL_WIDTH-1:0] v;
  logic [MW-1:0]          meta_datai;

  logic                   dvo;
  logic [DW-1:0]          dtypeo;
  logic [PIXEL_WIDTH-1:0] r;
  logic [PIXEL_WIDTH-1:0] g;
  logic [PIXEL_WIDTH-1:0] b;
  logic [MW-1:0]          meta_datao;

  modport slave (
    input  dvi, dtypei, y, u, v, meta_datai,
    output dvo, dtypeo, r, g, b, meta_datao
  );

  modport master (
    output dvi, dtypei, y, u, v, meta_datai,
    input  dvo, dtypeo, r, g, b, meta_datao
  );
endinterface

// File: rtl/yuv2rgb.sv
// yuv2rgb: 3-stage pipelined YUV -> RGB converter (products, rounded sums,
// clamped outputs), one pixel per clock, fixed 3-clock latency.
// Define YUV2RGB_422_EN for 4:2:2 input (chroma on u, alternating U/V);
// the default build treats every pixel as 4:4:4.
`ifndef DTYPE_WIDTH
`define DTYPE_WIDTH 4
`endif

module yuv2rgb #(
  parameter int unsigned PIXEL_WIDTH = 8
) (
  input  logic      clk,
  input  logic      resetb,
  input  logic      enable,
  yuv2rgb_if.slave  bus
);
  localparam int unsigned PW = PIXEL_WIDTH;
  localparam int unsigned CW = 11;
  localparam int unsigned SW = PIXEL_WIDTH + 12;
  localparam int unsigned DW = `DTYPE_WIDTH;
  localparam int unsigned MW = 16;

  localparam logic signed [CW-1:0] K_Y   = CW'(298);
  localparam logic signed [CW-1:0] K_RV  = CW'(409);
  localparam logic signed [CW-1:0] K_GU  = CW'(100);
  localparam logic signed [CW-1:0] K_GV  = CW'(208);
  localparam logic signed [CW-1:0] K_BU  = CW'(516);
  localparam logic signed [SW-1:0] K_RND = SW'(128);

  // Saturate a rounded sum into the unsigned pixel range.
  function automatic logic [PW-1:0] clamp(input logic signed [SW-1:0] s);
    logic [PW-1:0] res;
    if (s[SW-1])            res = '0;
    else if (|s[SW-2:PW])   res = '1;
    else                    res = s[PW-1:0];
    return res;
  endfunction

  logic signed [PW-1:0] cu_c;
  logic signed [PW-1:0] cv_c;
  logic [PW-1:0]        byp_b_c;

`ifdef YUV2RGB_422_EN
  logic          phase_q, phase_d;
  logic [PW-1:0] held_u_q, held_u_d;
  logic [PW-1:0] held_v_q, held_v_d;

  // Phase tracking and held chroma; blanking restarts the row at U with V=0.
  always_comb begin
    phase_d  = 1'b0;
    held_u_d = held_u_q;
    held_v_d = '0;
    if (bus.dvi) begin
      phase_d  = ~phase_q;
      held_v_d = held_v_q;
      if (!phase_q) held_u_d = bus.u;
      else          held_v_d = bus.u;
    end
    cu_c    = phase_q ? held_u_q : bus.u;
    cv_c    = phase_q ? bus.u : held_v_q;
    byp_b_c = bus.u;
  end

  // 4:2:2 phase and held chroma registers.
  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      phase_q  <= 1'b0;
      held_u_q <= '0;
      held_v_q <= '0;
    end else begin
      phase_q  <= phase_d;
      held_u_q <= held_u_d;
      held_v_q <= held_v_d;
    end
  end
`else
  // 4:4:4: chroma taken directly from u and v.
  always_comb begin
    cu_c    = bus.u;
    cv_c    = bus.v;
    byp_b_c = bus.v;
  end
`endif

  // Stage 1: signed coefficient products.
  logic signed [PW:0]   y_s_c;
  logic signed [SW-1:0] p_y_d, p_rv_d, p_gu_d, p_gv_d, p_bu_d;
  logic signed [SW-1:0] p_y_q, p_rv_q, p_gu_q, p_gv_q, p_bu_q;
  logic                 en1_q, dv1_q;
  logic [DW-1:0]        dt1_q;
  logic [MW-1:0]        md1_q;
  logic [PW-1:0]        byp1_r_q, byp1_g_q, byp1_b_q;

  // Products of luma and effective chroma with the fixed coefficients.
  always_comb begin
    y_s_c  = $signed({1'b0, bus.y});
    p_y_d  = SW'(y_s_c) * SW'(K_Y);
    p_rv_d = SW'(cv_c)  * SW'(K_RV);
    p_gu_d = SW'(cu_c)  * SW'(K_GU);
    p_gv_d = SW'(cv_c)  * SW'(K_GV);
    p_bu_d = SW'(cu_c)  * SW'(K_BU);
  end

  // Stage 1 registers: products, raw bypass values, enable and sideband.
  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      p_y_q <= '0; p_rv_q <= '0; p_gu_q <= '0; p_gv_q <= '0; p_bu_q <= '0;
      byp1_r_q <= '0; byp1_g_q <= '0; byp1_b_q <= '0;
      en1_q <= 1'b0; dv1_q <= 1'b0; dt1_q <= '0; md1_q <= '0;
    end else begin
      p_y_q <= p_y_d; p_rv_q <= p_rv_d; p_gu_q <= p_gu_d;
      p_gv_q <= p_gv_d; p_bu_q <= p_bu_d;
      byp1_r_q <= bus.y; byp1_g_q <= bus.u; byp1_b_q <= byp_b_c;
      en1_q <= enable; dv1_q <= bus.dvi; dt1_q <= bus.dtypei; md1_q <= bus.meta_datai;
    end
  end

  // Stage 2: rounded, floor-shifted sums.
  logic signed [SW-1:0] s_r_d, s_g_d, s_b_d;
  logic signed [SW-1:0] s_r_q, s_g_q, s_b_q;
  logic                 en2_q, dv2_q;
  logic [DW-1:0]        dt2_q;
  logic [MW-1:0]        md2_q;
  logic [PW-1:0]        byp2_r_q, byp2_g_q, byp2_b_q;

  // Sum products, add half an LSB, then arithmetic shift by 8.
  always_comb begin
    s_r_d = (p_y_q + p_rv_q + K_RND) >>> 8;
    s_g_d = (p_y_q - p_gu_q - p_gv_q + K_RND) >>> 8;
    s_b_d = (p_y_q + p_bu_q + K_RND) >>> 8;
  end

  // Stage 2 registers.
  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      s_r_q <= '0; s_g_q <= '0; s_b_q <= '0;
      byp2_r_q <= '0; byp2_g_q <= '0; byp2_b_q <= '0;
      en2_q <= 1'b0; dv2_q <= 1'b0; dt2_q <= '0; md2_q <= '0;
    end else begin
      s_r_q <= s_r_d; s_g_q <= s_g_d; s_b_q <= s_b_d;
      byp2_r_q <= byp1_r_q; byp2_g_q <= byp1_g_q; byp2_b_q <= byp1_b_q;
      en2_q <= en1_q; dv2_q <= dv1_q; dt2_q <= dt1_q; md2_q <= md1_q;
    end
  end

  // Stage 3: clamped result or bypass, selected by the pixel's own enable.
  logic [PW-1:0] r_d, g_d, b_d;
  logic [PW-1:0] r_q, g_q, b_q;
  logic          dv3_q;
  logic [DW-1:0] dt3_q;
  logic [MW-1:0] md3_q;

  // Output select between converted and bypassed components.
  always_comb begin
    r_d = byp2_r_q;
    g_d = byp2_g_q;
    b_d = byp2_b_q;
    if (en2_q) begin
      r_d = clamp(s_r_q);
      g_d = clamp(s_g_q);
      b_d = clamp(s_b_q);
    end
  end

  // Stage 3 output registers.
  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      r_q <= '0; g_q <= '0; b_q <= '0;
      dv3_q <= 1'b0; dt3_q <= '0; md3_q <= '0;
    end else begin
      r_q <= r_d; g_q <= g_d; b_q <= b_d;
      dv3_q <= dv2_q; dt3_q <= dt2_q; md3_q <= md2_q;
    end
  end

  assign bus.r          = r_q;
  assign bus.g          = g_q;
  assign bus.b          = b_q;
  assign bus.dvo        = dv3_q;
  assign bus.dtypeo     = dt3_q;
  assign bus.meta_datao = md3_q;

endmodule
